axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI slave front-end for one single-port synchronous SRAM macro; parametrised data/address/ID/length widths.
//  Full FIXED/INCR(/WRAP) burst address generation, narrow transfers, per-beat WSTRB, fair R/W arbitration.
//  Sits behind the AXI interconnect; exposes a generic SRAM pin bundle (1-cycle read latency) to the macro shell.
// PARAMETERS
//  ID_W     8   AXI ID width (bid/rid echo the sampled awid/arid)
//  ADDR_W   32  AXI address width
//  DATA_W   32  data width; power of 2, >=32; STRB_W = DATA_W/8, OFF_W = log2(STRB_W)
//  LEN_W    4   AXI len width (max burst = 2**LEN_W beats)
//  SRAM_AW  14  SRAM word-address width; word index = addr[OFF_W+:SRAM_AW], upper bits ignored
// PORTS
//  clk                      in   1        clock
//  rst                      in   1        asynchronous reset, active-low
//  aw{id,addr,len,size,burst} in ID_W/ADDR_W/LEN_W/3/2  write address payload
//  awvalid / awready        in/out 1      AW handshake
//  wdata, wstrb, wlast      in   DATA_W/STRB_W/1  write data payload
//  wvalid / wready          in/out 1      W handshake
//  bid, bresp               out  ID_W/2   write response
//  bvalid / bready          out/in 1      B handshake
//  ar{id,addr,len,size,burst} in ID_W/ADDR_W/LEN_W/3/2  read address payload
//  arvalid / arready        in/out 1      AR handshake
//  rid, rdata, rresp, rlast out  ID_W/DATA_W/2/1  read data payload
//  rvalid / rready          out/in 1      R handshake
//  sram_cs, sram_oe         out  1        chip select / output enable
//  sram_web                 out  STRB_W   per-byte write enable, active-low
//  sram_a, sram_di          out  SRAM_AW/DATA_W  address / write data
//  sram_do                  in   DATA_W   read data, valid one cycle after address with cs&oe
// BEHAVIOUR
//  While rst low: state IDLE, cnt 0, last_grant=WRITE, all outputs 0 (sram_web all 1s); reset mid-burst abandons it.
//  States: IDLE -> RD (arhns) | WR (awhns); WR -> WRESP on final W beat; RD/WRESP -> IDLE on final rhns/bhns.
//  IDLE: awready = arready = 1 except both valid -> only the side != last_grant is ready; W never ready in IDLE.
//  Payload (id,len,size,burst,addr) sampled on handshake; size > OFF_W clamped to OFF_W.
//  Read: sram_a = araddr word in the arhns cycle; rvalid asserts next cycle, rdata = sram_do direct.
//   Back-to-back beats each cycle rready=1; on stall sram_a held so sram_do stays stable; rlast = (cnt==len).
//  Write: wready=1 in WR; each whns writes sram_di=wdata, sram_web=~wstrb at current beat address (no read-modify-write).
//   Burst ends on beat cnt==len regardless of wlast; bresp=SLVERR if wlast!=(cnt==len) on any beat, else OKAY.
//  WRESP: bvalid=1 until bready; bid = sampled awid. rresp always OKAY. Valids never depend on readies.
//  Address step: FIXED none; INCR addr = aligned(addr)+(1<<size), wraps mod 2**SRAM_AW words; reserved burst (2'b11) = INCR.
//  cnt counts beats 0..len, cleared at burst end; minimum one IDLE cycle between transactions.
// CONFIGURATION
//  AXI_SRAM_WRAP_EN defined: WRAP bursts wrap on (len+1)<<size aligned boundary; len not in {1,3,7,15} -> SLVERR, no write.
//  Not defined: WRAP treated exactly as INCR; resp OKAY.
// STRUCTURE
//  axi_sram_pkg: burst_e (FIXED/INCR/WRAP), RESP_OKAY/RESP_SLVERR, state_e, grant_e.
//  Sub-module axi_burst_addr_gen: sampled addr/len/size/burst + advance -> current/next byte address.
// TESTING
//  Single read @0x40 with mem[16]=0xDEADBEEF, rready=1 -> rvalid cycle after arhns, rdata=0xDEADBEEF, rlast=1.
//  INCR write len=3 size=2 @0x100, wstrb=F,3,C,1 -> words 64..67 byte-masked; bresp OKAY, bid=awid.
//  INCR read len=7 with rready toggling 1/0 -> 8 beats in order, rdata stable during stall, rlast only on beat 7.
//  awvalid & arvalid together, 4 times -> grants alternate R,W,R,W starting with read after reset.
//  Write len=3 with wlast on beat 1 -> 4 beats written, bresp=SLVERR.
//  WRAP len=3 size=2 @0x0C (WRAP_EN) -> beat addrs 0x0C,0x00,0x04,0x08; without macro -> 0x0C,0x10,0x14,0x18.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: shared types for the AXI-to-SRAM slave.
// WRAP burst support is compiled in with AXI_SRAM_WRAP_EN.
package axi_sram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WRESP
    } state_e;

    typedef enum logic {
        GRANT_WRITE,
        GRANT_READ
    } grant_e;

    function automatic logic [2:0] clamp_size(
        input logic [2:0] size,
        input logic [2:0] max_size
    );
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/axi_sram_slave_addr_gen.sv
// axi_burst_addr_gen: per-beat byte address for FIXED/INCR bursts,
// plus WRAP bursts when AXI_SRAM_WRAP_EN is defined.
module axi_burst_addr_gen
    import axi_sram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              advance_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] cur_addr_o,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              wrap_err_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] step, aligned, incr, wrap_mask;
    logic              len_pow2;
    logic              wrap_ok;

    always_comb begin
        step      = ADDR_W'(1) << size_i;
        aligned   = addr_q & ~(step - ADDR_W'(1));
        incr      = aligned + step;
        wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        len_pow2  = (len_i != '0) && ((len_i & (len_i + LEN_W'(1))) == '0);
    end

`ifdef AXI_SRAM_WRAP_EN
    assign wrap_ok    = (burst_i == BURST_WRAP) && len_pow2;
    assign wrap_err_o = (burst_i == BURST_WRAP) && !len_pow2;
`else
    logic unused_wrap;
    assign unused_wrap = ^{len_pow2, wrap_mask};
    assign wrap_ok     = 1'b0;
    assign wrap_err_o  = 1'b0;
`endif

    always_comb begin
        next_addr_o = incr;
        unique case (1'b1)
            burst_i == BURST_FIXED: next_addr_o = addr_q;
            wrap_ok:                next_addr_o = (addr_q & ~wrap_mask) | (incr & wrap_mask);
            default:                next_addr_o = incr;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = addr_i;
        end else if (advance_i) begin
            addr_d = next_addr_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign cur_addr_o = addr_q;

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI slave in front of a 1-cycle-latency single-port SRAM.
// Define AXI_SRAM_WRAP_EN to honour WRAP bursts; otherwise WRAP acts as INCR.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic [LEN_W-1:0]    awlen_i,
    input  logic [2:0]          awsize_i,
    input  logic [1:0]          awburst_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i,
    input  logic [ID_W-1:0]     arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic [LEN_W-1:0]    arlen_i,
    input  logic [2:0]          arsize_i,
    input  logic [1:0]          arburst_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic                sram_cs_o,
    output logic                sram_oe_o,
    output logic [DATA_W/8-1:0] sram_web_o,
    output logic [SRAM_AW-1:0]  sram_a_o,
    output logic [DATA_W-1:0]   sram_di_o,
    input  logic [DATA_W-1:0]   sram_do_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [2:0] OFF_SZ = 3'(OFF_W);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, len_q;
    logic [ID_W-1:0]   id_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              werr_q;

    logic              in_idle, in_rd, in_wr, in_wresp;
    logic              both_valid, aw_rdy, ar_rdy;
    logic              aw_hs, ar_hs, w_hs, r_hs, b_hs, last_beat;
    logic [ADDR_W-1:0] ld_addr, cur_addr, next_addr, rd_addr;
    logic              wrap_err;
    logic              unused_addr;

    assign in_idle  = state_q == ST_IDLE;
    assign in_rd    = state_q == ST_RD;
    assign in_wr    = state_q == ST_WR;
    assign in_wresp = state_q == ST_WRESP;

    // Contention goes to the side that did not win last time.
    assign both_valid = awvalid_i && arvalid_i;
    assign aw_rdy = rst && in_idle && !(both_valid && last_grant_q == GRANT_WRITE);
    assign ar_rdy = rst && in_idle && !(both_valid && last_grant_q == GRANT_READ);

    assign aw_hs     = awvalid_i && aw_rdy;
    assign ar_hs     = arvalid_i && ar_rdy;
    assign w_hs      = wvalid_i && in_wr;
    assign r_hs      = in_rd && rready_i;
    assign b_hs      = in_wresp && bready_i;
    assign last_beat = cnt_q == len_q;
    assign ld_addr   = ar_hs ? araddr_i : awaddr_i;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ar_hs || aw_hs),
        .addr_i      (ld_addr),
        .advance_i   (r_hs || w_hs),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .cur_addr_o  (cur_addr),
        .next_addr_o (next_addr),
        .wrap_err_o  (wrap_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (r_hs || w_hs) begin
            cnt_d = last_beat ? '0 : cnt_q + LEN_W'(1);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d      = ST_RD;
                    last_grant_d = GRANT_READ;
                end else if (aw_hs) begin
                    state_d      = ST_WR;
                    last_grant_d = GRANT_WRITE;
                end
            end
            ST_RD:    if (r_hs && last_beat) state_d = ST_IDLE;
            ST_WR:    if (w_hs && last_beat) state_d = ST_WRESP;
            ST_WRESP: if (b_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            last_grant_q <= GRANT_WRITE;
            id_q         <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            werr_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            if (ar_hs) begin
                id_q    <= arid_i;
                len_q   <= arlen_i;
                size_q  <= clamp_size(arsize_i, OFF_SZ);
                burst_q <= arburst_i;
            end else if (aw_hs) begin
                id_q    <= awid_i;
                len_q   <= awlen_i;
                size_q  <= clamp_size(awsize_i, OFF_SZ);
                burst_q <= awburst_i;
                werr_q  <= 1'b0;
            end else if (w_hs) begin
                werr_q  <= werr_q | (wlast_i != last_beat);
            end
        end
    end

    always_comb begin
        awready_o  = aw_rdy;
        arready_o  = ar_rdy;
        wready_o   = in_wr;
        rvalid_o   = in_rd;
        bvalid_o   = in_wresp;
        rlast_o    = in_rd && last_beat;
        rdata_o    = in_rd ? sram_do_i : '0;
        rid_o      = id_q;
        bid_o      = id_q;
        rresp_o    = RESP_OKAY;
        bresp_o    = (in_wresp && (werr_q || wrap_err)) ? RESP_SLVERR : RESP_OKAY;
        sram_cs_o  = 1'b0;
        sram_oe_o  = 1'b0;
        sram_web_o = '1;
        sram_a_o   = '0;
        sram_di_o  = '0;
        // On a stall the current beat is re-read so sram_do_i stays put.
        rd_addr    = r_hs ? next_addr : cur_addr;
        unique case (1'b1)
            ar_hs: begin
                sram_cs_o = 1'b1;
                sram_oe_o = 1'b1;
                sram_a_o  = araddr_i[OFF_W +: SRAM_AW];
            end
            in_rd: begin
                sram_cs_o = 1'b1;
                sram_oe_o = 1'b1;
                sram_a_o  = rd_addr[OFF_W +: SRAM_AW];
            end
            w_hs && !wrap_err: begin
                sram_cs_o  = 1'b1;
                sram_web_o = ~wstrb_i;
                sram_a_o   = cur_addr[OFF_W +: SRAM_AW];
                sram_di_o  = wdata_i;
            end
            default: ;
        endcase
    end

    assign unused_addr = ^rd_addr;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized AXI traffic against a byte-level memory
// model with addresses derived from the AXI burst address equations.
module tb_axi_sram_slave;

    localparam int ID_W    = 8;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int SRAM_AW = 14;
    localparam int STRB_W  = DATA_W / 8;
    localparam int OFF_W   = $clog2(STRB_W);
    localparam int WORDS   = 1 << SRAM_AW;
`ifdef AXI_SRAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [ID_W-1:0]   awid_i = '0, arid_i = '0;
    logic [ADDR_W-1:0] awaddr_i = '0, araddr_i = '0;
    logic [LEN_W-1:0]  awlen_i = '0, arlen_i = '0;
    logic [2:0]        awsize_i = '0, arsize_i = '0;
    logic [1:0]        awburst_i = '0, arburst_i = '0;
    logic              awvalid_i = 1'b0, arvalid_i = 1'b0;
    logic [DATA_W-1:0] wdata_i = '0;
    logic [STRB_W-1:0] wstrb_i = '0;
    logic              wlast_i = 1'b0, wvalid_i = 1'b0;
    logic              bready_i = 1'b0, rready_i = 1'b0;
    logic              awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o;
    logic [ID_W-1:0]   bid_o, rid_o;
    logic [1:0]        bresp_o, rresp_o;
    logic [DATA_W-1:0] rdata_o, sram_di_o, sram_do_i;
    logic              sram_cs_o, sram_oe_o;
    logic [STRB_W-1:0] sram_web_o;
    logic [SRAM_AW-1:0] sram_a_o;

    logic [DATA_W-1:0] mem     [WORDS];
    logic [DATA_W-1:0] ref_mem [WORDS];
    logic [STRB_W-1:0] strb_tab[$];
    int                wr_log[$];
    int                n_chk = 0;
    int                n_err = 0;

    axi_sram_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SRAM_AW(SRAM_AW)
    ) dut (
        .clk(clk), .rst(rst),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i),
        .sram_cs_o(sram_cs_o), .sram_oe_o(sram_oe_o), .sram_web_o(sram_web_o),
        .sram_a_o(sram_a_o), .sram_di_o(sram_di_o), .sram_do_i(sram_do_i)
    );

    always #5 clk = ~clk;

    // SRAM macro: byte-masked write, registered read
    always @(posedge clk) begin
        if (sram_cs_o) begin
            if (sram_web_o != '1) wr_log.push_back(int'(sram_a_o));
            for (int b = 0; b < STRB_W; b++)
                if (!sram_web_o[b]) mem[sram_a_o][b*8 +: 8] <= sram_di_o[b*8 +: 8];
            if (sram_oe_o) sram_do_i <= mem[sram_a_o];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit wrap_bad(input int len, input int burst);
        return WRAP_EN && burst == 2 && !(len inside {1, 3, 7, 15});
    endfunction

    function automatic int beat_word(input int unsigned addr, input int len,
                                     input int size, input int burst, input int i);
        longint unsigned nb, al, a, tot, bnd;
        nb = 64'(1) << ((size > OFF_W) ? OFF_W : size);
        al = (64'(addr) / nb) * nb;
        if (burst == 0 || i == 0) a = 64'(addr);
        else a = al + 64'(i) * nb;
        if (WRAP_EN && burst == 2 && !wrap_bad(len, burst)) begin
            tot = nb * 64'(len + 1);
            bnd = (64'(addr) / tot) * tot;
            a = al + 64'(i) * nb;
            if (a >= bnd + tot) a = a - tot;
        end
        return int'((a / STRB_W) % WORDS);
    endfunction

    task automatic send_ar(input logic [7:0] id, input int unsigned addr, input int len,
                           input int size, input int burst, output bit ok);
        int cyc = 0;
        arid_i = id; araddr_i = addr; arlen_i = LEN_W'(len);
        arsize_i = 3'(size); arburst_i = 2'(burst); arvalid_i = 1'b1;
        do begin @(negedge clk); cyc++; end while (!arready_o && cyc < 50);
        ok = arready_o;
        if (!ok) chk("ar_timeout", 0, 1);
        else begin @(posedge clk); #1; end
        arvalid_i = 1'b0;
    endtask

    task automatic send_aw(input logic [7:0] id, input int unsigned addr, input int len,
                           input int size, input int burst, output bit ok);
        int cyc = 0;
        awid_i = id; awaddr_i = addr; awlen_i = LEN_W'(len);
        awsize_i = 3'(size); awburst_i = 2'(burst); awvalid_i = 1'b1;
        do begin @(negedge clk); cyc++; end while (!awready_o && cyc < 50);
        ok = awready_o;
        if (!ok) chk("aw_timeout", 0, 1);
        else begin @(posedge clk); #1; end
        awvalid_i = 1'b0;
    endtask

    task automatic recv_r(input logic [7:0] id, input int unsigned addr, input int len,
                          input int size, input int burst, input bit stall);
        int i = 0;
        int cyc = 0;
        int w;
        rready_i = 1'b1;
        while (i <= len && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("r_latency", rvalid_o, 1);
            if (rvalid_o) begin
                w = beat_word(addr, len, size, burst, i);
                chk("rdata", rdata_o, ref_mem[w]);
                chk("rlast", rlast_o, i == len);
                chk("rid", rid_o, id);
                chk("rresp", rresp_o, 0);
                if (rready_i) i++;
            end
            @(posedge clk);
            #1;
            rready_i = stall ? !rready_i : 1'b1;
        end
        if (i <= len) chk("r_timeout", i, len + 1);
        rready_i = 1'b0;
    endtask

    task automatic send_w(input int unsigned addr, input int len, input int size,
                          input int burst, input int bad);
        int cyc;
        int w;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            wdata_i  = $urandom;
            wstrb_i  = (strb_tab.size() != 0) ? strb_tab.pop_front() : STRB_W'($urandom);
            wlast_i  = (bad >= 0) ? (i == bad) : (i == len);
            wvalid_i = 1'b1;
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!wready_o && cyc < 50);
            if (!wready_o) begin
                chk("w_timeout", i, len + 1);
                break;
            end
            @(posedge clk);
            #1;
            if (!wrap_bad(len, burst)) begin
                w = beat_word(addr, len, size, burst, i);
                for (int b = 0; b < STRB_W; b++)
                    if (wstrb_i[b]) ref_mem[w][b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
        wvalid_i = 1'b0;
        wlast_i  = 1'b0;
    endtask

    task automatic recv_b(input logic [7:0] id, input logic [1:0] exp_resp);
        int cyc = 0;
        bready_i = 1'b0;
        do begin @(negedge clk); cyc++; end while (!bvalid_o && cyc < 50);
        chk("bvalid", bvalid_o, 1);
        chk("bid", bid_o, id);
        chk("bresp", bresp_o, exp_resp);
        bready_i = 1'b1;
        @(posedge clk);
        #1;
        bready_i = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] id, input int unsigned addr, input int len,
                            input int size, input int burst, input int bad);
        bit ok;
        logic [1:0] exp;
        exp = (wrap_bad(len, burst) || (bad >= 0 && bad != len)) ? 2'b10 : 2'b00;
        send_aw(id, addr, len, size, burst, ok);
        if (ok) begin
            send_w(addr, len, size, burst, bad);
            recv_b(id, exp);
        end
    endtask

    task automatic do_read(input logic [7:0] id, input int unsigned addr, input int len,
                           input int size, input int burst, input bit stall);
        bit ok;
        send_ar(id, addr, len, size, burst, ok);
        if (ok) recv_r(id, addr, len, size, burst, stall);
    endtask

    task automatic arb_round(input int k, input bit exp_read);
        bit rd;
        bit wr;
        arid_i = 8'(8'h10 + k); araddr_i = 32'h40; arlen_i = '0;
        arsize_i = 3'd2; arburst_i = 2'd1;
        awid_i = 8'(8'h20 + k); awaddr_i = 32'h200 + 32'(k * 4); awlen_i = '0;
        awsize_i = 3'd2; awburst_i = 2'd1;
        arvalid_i = 1'b1;
        awvalid_i = 1'b1;
        @(negedge clk);
        chk("arb_grant", {awready_o, arready_o}, exp_read ? 2'b01 : 2'b10);
        rd = arready_o;
        wr = awready_o;
        @(posedge clk);
        #1;
        arvalid_i = 1'b0;
        awvalid_i = 1'b0;
        if (rd) recv_r(8'(8'h10 + k), 32'h40, 0, 2, 1, 1'b0);
        else if (wr) begin
            send_w(32'h200 + 32'(k * 4), 0, 2, 1, -1);
            recv_b(8'(8'h20 + k), 2'b00);
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;

        awvalid_i = 1'b1;
        arvalid_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready_o, 0);
        chk("rst_arready", arready_o, 0);
        chk("rst_valids", {wready_o, bvalid_o, rvalid_o}, 0);
        chk("rst_sram", {sram_cs_o, sram_oe_o, sram_web_o}, {2'b00, {STRB_W{1'b1}}});
        awvalid_i = 1'b0;
        arvalid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) arb_round(k, (k % 2) == 0);

        do_read(8'h01, 32'h40, 0, 2, 1, 1'b0);

        for (int i = 0; i < 4; i++) strb_tab.push_back(STRB_W'(4'hF >> (i == 1 ? 2 : 0)));
        strb_tab.delete();
        strb_tab.push_back(4'hF);
        strb_tab.push_back(4'h3);
        strb_tab.push_back(4'hC);
        strb_tab.push_back(4'h1);
        wr_log.delete();
        do_write(8'h5A, 32'h100, 3, 2, 1, -1);
        chk("incr_nbeats", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("incr_word", (i < wr_log.size()) ? wr_log[i] : -1, 64 + i);
        do_read(8'h5B, 32'h100, 3, 2, 1, 1'b0);

        do_read(8'h33, 32'h200, 7, 2, 1, 1'b1);

        wr_log.delete();
        do_write(8'h44, 32'h180, 3, 2, 1, 1);
        chk("early_wlast_beats", wr_log.size(), 4);
        do_read(8'h45, 32'h180, 3, 2, 1, 1'b0);

        for (int i = 0; i < 4; i++) strb_tab.push_back('1);
        wr_log.delete();
        do_write(8'h66, 32'h0C, 3, 2, 2, -1);
        chk("wrap_nbeats", wr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("wrap_word", (i < wr_log.size()) ? wr_log[i] : -1, WRAP_EN ? (3 + i) % 4 : 3 + i);
        do_read(8'h67, 32'h0C, 3, 2, 2, 1'b0);

        do_write(8'h70, 32'hFFF8, 3, 2, 1, -1);
        do_read(8'h71, 32'hFFF8, 3, 2, 1, 1'b1);
        do_write(8'h72, 32'h2A1, 5, 0, 0, -1);
        do_read(8'h73, 32'h2A0, 1, 3, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int unsigned sz, bu, ln, ad, nb;
            int bad;
            sz = $urandom_range(0, 3);
            bu = $urandom_range(0, 3);
            ln = $urandom_range(0, 15);
            nb = 1 << ((sz > OFF_W) ? OFF_W : sz);
            ad = $urandom_range(0, 2047);
            if (bu == 2) ad = (ad / nb) * nb;
            if ($urandom_range(0, 1) == 1) begin
                bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ln)) : -1;
                do_write(8'($urandom), ad, int'(ln), int'(sz), int'(bu), bad);
            end else begin
                if (WRAP_EN && bu == 2) ln = (1 << $urandom_range(1, 4)) - 1;
                do_read(8'($urandom), ad, int'(ln), int'(sz), int'(bu), 1'($urandom));
            end
        end

        begin
            bit ok;
            send_ar(8'h99, 32'h300, 7, 2, 1, ok);
            rready_i = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            #1;
            chk("midrst_rvalid", rvalid_o, 0);
            chk("midrst_rlast", rlast_o, 0);
            chk("midrst_sram", {sram_cs_o, sram_web_o}, {1'b0, {STRB_W{1'b1}}});
            chk("midrst_arready", arready_o, 0);
            rready_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
        end
        arb_round(4, 1'b1);
        do_read(8'h9A, 32'h300, 7, 2, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
